// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] sel2grant(input logic [SEL_W-1:0] s);
    logic [NREQ-1:0] g;
    g    = '0;
    g[s] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Request/data/grant bundle between requesters (master) and the arbiter (slave).
interface mux_rr_arb_if;
  import mux_arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  in;
  logic [NREQ-1:0]  grant;
  logic [SEL_W-1:0] sel;
  logic             out;
  logic             busy;

  modport master (
    output req,
    output in,
    input  grant,
    input  sel,
    input  out,
    input  busy
  );

  modport slave (
    input  req,
    input  in,
    output grant,
    output sel,
    output out,
    output busy
  );

endinterface

// File: rtl/mux_rr_arb_mux.sv
// Plain 8:1 data mux: picks one requester's data bit by select index.
module mux_rr_arb_mux
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  data_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             y_o
);

  assign y_o = data_i[sel_i];

endmodule

// File: rtl/mux_rr_arb.sv
// Round-robin arbiter owning a shared 8:1 mux path; optional hold timeout
// is compiled in with MUX_RR_ARB_TIMEOUT_EN.
module mux_rr_arb
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic         clk,
  input  logic         rst,
  mux_rr_arb_if.slave  bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux_rr_arb: HOLD_MAX out of range 2..255");
  end

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  req_rot;
  logic [SEL_W-1:0] offset;
  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic             hold_expired;
  logic             mux_y;

  // Rotate requests so the current pointer sits at bit 0; the lowest set bit
  // of the rotated vector is then the round-robin winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign req_rot[gi] = bus.req[ptr_q + SEL_W'(gi)];
  end

  always_comb begin
    offset = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = SEL_W'(k);
      end
    end
  end

  assign winner  = ptr_q + offset;
  assign any_req = |bus.req;

`ifdef MUX_RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Counts completed GRANT cycles; zero on the first cycle of each tenure.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign hold_expired = (state_q == GRANT) && (hold_cnt_q == 8'(HOLD_MAX - 1));
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          grant_d = sel2grant(winner);
          sel_d   = winner;
          busy_d  = 1'b1;
          ptr_d   = winner + SEL_W'(1);
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || hold_expired) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  mux_rr_arb_mux u_mux (
    .data_i (bus.in),
    .sel_i  (sel_q),
    .y_o    (mux_y)
  );

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.out   = busy_q & mux_y;

endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter HOLD_MAX, default 16, meaning: maximum consecutive GRANT cycles per tenure, legal range 2..255; used only when timeout is compiled in.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request lines; bit i set = requester i wants the shared 8:1 mux path.
REQ-005 in  input  8  data bits; bit i is requester i's data.
REQ-006 grant  output  8  one-hot grant, registered; all zero when idle.
REQ-007 sel  output  3  registered mux select; equals index of the set grant bit.
REQ-008 out  output  1  in[sel] while busy=1, else 0.
REQ-009 busy  output  1  registered; 1 exactly when grant is non-zero.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with grant=0, busy=0 and sel holding its last value.
REQ-012 In IDLE with req!=0 at edge N, the block SHALL enter GRANT at edge N and present grant/sel/busy from edge N onward. Latency is 1 cycle from req to grant.
REQ-013 The winner SHALL be the first set req bit found scanning upward from ptr and wrapping 7->0.
REQ-014 ptr SHALL be a 3-bit register, reset to 0, and SHALL be loaded with winner+1 (mod 8) at each grant.
REQ-015 In GRANT, the grant SHALL hold while req[sel]=1, regardless of other req bits.
REQ-016 In GRANT, req[sel]=0 sampled at an edge SHALL return the FSM to IDLE, with grant=0 and busy=0 from that edge.
REQ-017 Every grant tenure SHALL be followed by at least one IDLE cycle.
REQ-018 Requests from non-granted requesters that rise or fall during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-019 grant SHALL never have more than one bit set.
REQ-020 sel SHALL change only on entry to GRANT.
REQ-021 out SHALL be combinational from in and the registered sel/busy, with no added latency.
REQ-022 A requester that deasserts req in the same cycle its grant appears SHALL still hold grant for that cycle and lose it at the next edge.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set state=IDLE, grant=0, sel=0, busy=0, ptr=0 and hold counter=0, overriding every other condition, including mid-tenure.
REQ-024 In the first edge after rst deasserts, the block SHALL arbitrate normally from ptr=0.

Configuration
REQ-025 The macro MUX_RR_ARB_TIMEOUT_EN SHALL control the hold timeout.
REQ-026 With MUX_RR_ARB_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-027 With MUX_RR_ARB_TIMEOUT_EN defined, once the holder has had HOLD_MAX grant cycles, the FSM SHALL return to IDLE even if req[sel]=1. ptr is already advanced, so other requesters win next.
REQ-028 With MUX_RR_ARB_TIMEOUT_EN undefined, no counter SHALL exist and tenure SHALL be unbounded.

Structure
REQ-029 Shared package mux_arb_pkg SHALL hold the constants NREQ=8 and SEL_W=3 and the state encoding (IDLE=0, GRANT=1).
REQ-030 The existing mux module SHALL be instantiated as the single sub-module for the data path, driven by in and sel; its output is gated by busy.
REQ-031 The round-robin priority scan SHALL be inline combinational logic, not a separate module.

Verification
REQ-032 Reset then req=8'b0000_0100 at cycle 1 -> cycle 2: grant=8'b0000_0100, sel=3'd2, busy=1; out follows in[2].
REQ-033 req=8'b1000_0001 held after reset -> requester 0 is granted first; after req[0] drops -> one IDLE cycle, then grant=8'b1000_0000, sel=7.
REQ-034 ptr=7, req=8'b1000_0010 -> requester 7 wins; ptr wraps to 0, so the next winner is requester 1.
REQ-035 rst pulsed for one cycle while grant=8'b0001_0000 -> next edge grant=0, busy=0, sel=0, ptr=0.
REQ-036 With MUX_RR_ARB_TIMEOUT_EN and HOLD_MAX=4, req=8'b0000_0011 held -> requester 0 holds 4 cycles, one IDLE cycle, then requester 1 holds 4 cycles, alternating.
REQ-037 Check on every cycle of every test: grant is one-hot or zero, busy==|grant, and out==(busy ? in[sel] : 0).
